// File: rtl/des_iter_engine.sv
// Iterative single-DES block engine: configurable rounds per clock, enc/dec, ECB/CBC, valid/ready.
// state | meaning: IDLE accept block / iv_load | ROUND Feistel rounds | DONE out_data held until out_ready
module des_iter_engine #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [63:0] key_din,
  input  logic        mode_dec,
  input  logic        cbc_en,
  input  logic        iv_load,
  input  logic [63:0] iv_din,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy
);

  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
      ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : g_bad_rpc
    $error("des_iter_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam int N_ITER = 16 / ROUNDS_PER_CYCLE;
  localparam logic [3:0] ITER_LAST = 4'(N_ITER - 1);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_ROUND = 2'b01;
  localparam logic [1:0] S_DONE  = 2'b10;

  localparam int IP_T [64] = '{
    58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
    57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{
    40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
    36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{
    32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{
    16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{
    57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
    63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{
    14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SBOX_T [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,     0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,     15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,     3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,     13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,     13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,     1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,     13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,     3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,     14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,     11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,     10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,     4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,     13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,     6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,     1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,     2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  // Tables use DES numbering: DES bit n of a W-bit word is vector bit W-n.
  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] expand(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] perm_p(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] sbox(input logic [47:0] x);
    logic [31:0] y;
    logic [5:0]  six;
    y = '0;
    for (int b = 0; b < 8; b++) begin
      six = x[47-6*b -: 6];
      y[31-4*b -: 4] = 4'(SBOX_T[b*64 + int'({six[5], six[0]})*16 + int'(six[4:1])]);
    end
    return y;
  endfunction

  // Decrypt walks the schedule backwards: K16 comes from the unrotated C/D.
  function automatic int shift_amt(input logic [3:0] rnd, input logic dec);
    if (dec && rnd == 4'd0) return 0;
    if (dec) return (rnd == 4'd1 || rnd == 4'd8 || rnd == 4'd15) ? 1 : 2;
    return (rnd == 4'd0 || rnd == 4'd1 || rnd == 4'd8 || rnd == 4'd15) ? 1 : 2;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input int n, input logic right);
    if (n == 0) return x;
    if (right) return (n == 1) ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    return (n == 1) ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  logic [1:0]  state_q;
  logic [31:0] l_q, r_q;
  logic [27:0] c_q, d_q;
  logic [3:0]  iter_q;
  logic        dec_q, cbc_q;
  logic [63:0] chain_q, cin_q;

  logic [31:0] l_n, r_n, f_out, tmp;
  logic [27:0] c_n, d_n;
  logic [47:0] k_sub;
  logic [3:0]  rnd;
  int          amt;
  logic [63:0] y_blk, blk_in;
  logic        unused_parity;

  assign unused_parity = ^{key_din[56], key_din[48], key_din[40], key_din[32],
                           key_din[24], key_din[16], key_din[8], key_din[0]};

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);

  // An iv_load on the accept edge supplies the chain value for this very block.
  assign blk_in = in_data ^ ((cbc_en && !mode_dec) ? (iv_load ? iv_din : chain_q) : 64'h0);

  always_comb begin
    l_n   = l_q;
    r_n   = r_q;
    c_n   = c_q;
    d_n   = d_q;
    f_out = '0;
    tmp   = '0;
    k_sub = '0;
    rnd   = '0;
    amt   = 0;
    for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
      rnd   = 4'(int'(iter_q) * ROUNDS_PER_CYCLE + k);
      amt   = shift_amt(rnd, dec_q);
      c_n   = rot28(c_n, amt, dec_q);
      d_n   = rot28(d_n, amt, dec_q);
      k_sub = perm_pc2({c_n, d_n});
      f_out = perm_p(sbox(expand(r_n) ^ k_sub));
      tmp   = r_n;
      r_n   = l_n ^ f_out;
      l_n   = tmp;
    end
    y_blk = perm_fp({r_n, l_n});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      l_q      <= '0;
      r_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      iter_q   <= '0;
      dec_q    <= 1'b0;
      cbc_q    <= 1'b0;
      chain_q  <= '0;
      cin_q    <= '0;
      out_data <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (iv_load) chain_q <= iv_din;
          if (in_valid) begin
            dec_q      <= mode_dec;
            cbc_q      <= cbc_en;
            {c_q, d_q} <= perm_pc1(key_din);
            {l_q, r_q} <= perm_ip(blk_in);
            iter_q     <= '0;
            if (cbc_en && mode_dec) cin_q <= in_data;
            state_q    <= S_ROUND;
          end
        end
        S_ROUND: begin
          l_q    <= l_n;
          r_q    <= r_n;
          c_q    <= c_n;
          d_q    <= d_n;
          iter_q <= iter_q + 4'd1;
          if (iter_q == ITER_LAST) begin
            out_data <= y_blk ^ ((cbc_q && dec_q) ? chain_q : 64'h0);
            if (cbc_q) chain_q <= dec_q ? cin_q : y_blk;
            state_q  <= S_DONE;
          end
        end
        S_DONE: if (out_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
